// File: rtl/lock_sequencer.sv
`timescale 1ns/1ps
// lock_sequencer: keypad front end for the lock datapath; forwards one press per try pulse,
// checks the result on enter, holds the unlocked window and enforces a lockout after repeated failures.
module lock_sequencer #(
  parameter int unsigned MAX_PRESSES    = 10,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned OPEN_CYCLES    = 1000,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           key_valid,
  input  logic [3:0]                     key,
  input  logic                           enter,
  input  logic                           clear,
  input  logic                           lock_open,
  output logic                           lock_reset,
  output logic [3:0]                     lock_numbers,
  output logic                           lock_try,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic                           key_error
);

  localparam int unsigned FAIL_W    = $clog2(MAX_FAILS + 1);
  localparam int unsigned PRESS_W   = $clog2(MAX_PRESSES + 1);
  localparam int unsigned TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

  typedef enum logic [2:0] {
    S_CLR     = 3'd0,
    S_IDLE    = 3'd1,
    S_ENTRY   = 3'd2,
    S_CHECK   = 3'd3,
    S_OPEN    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [PRESS_W-1:0]  press_q, press_d;
  logic [FAIL_W-1:0]   fail_d;
  logic [3:0]          numbers_d;
  logic                try_d;
  logic                error_d;
  logic                key_onehot;

  // Next-state and next-output logic; clear > enter > key_valid.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    press_d    = press_q;
    fail_d     = fail_count;
    numbers_d  = lock_numbers;
    try_d      = 1'b0;
    error_d    = 1'b0;
    key_onehot = (key != 4'd0) && ((key & (key - 4'd1)) == 4'd0);

    unique case (state_q)
      S_CLR: begin
        press_d = '0;
        state_d = S_IDLE;
      end
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          state_d = S_CLR;
        end else if (enter) begin
          if (state_q == S_ENTRY) state_d = S_CHECK;
        end else if (key_valid) begin
          if (key_onehot && (press_q < PRESS_W'(MAX_PRESSES))) begin
            numbers_d = key;
            try_d     = 1'b1;
            press_d   = press_q + PRESS_W'(1);
            state_d   = S_ENTRY;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (lock_open) begin
          state_d = S_OPEN;
          timer_d = TIMER_W'(OPEN_CYCLES - 1);
          fail_d  = '0;
        end else begin
          if (fail_count < FAIL_W'(MAX_FAILS)) fail_d = fail_count + FAIL_W'(1);
          if (fail_d == FAIL_W'(MAX_FAILS)) begin
            state_d = S_LOCKOUT;
            timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_OPEN: begin
        if (clear || (timer_q == '0)) state_d = S_CLR;
        else                          timer_d = timer_q - TIMER_W'(1);
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_CLR;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  // State, counters and registered outputs; status outputs decode the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CLR;
      timer_q      <= '0;
      press_q      <= '0;
      lock_reset   <= 1'b1;
      lock_numbers <= 4'd0;
      lock_try     <= 1'b0;
      unlocked     <= 1'b0;
      locked_out   <= 1'b0;
      fail_count   <= '0;
      key_error    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      press_q      <= press_d;
      lock_reset   <= (state_d == S_CLR);
      lock_numbers <= numbers_d;
      lock_try     <= try_d;
      unlocked     <= (state_d == S_OPEN);
      locked_out   <= (state_d == S_LOCKOUT);
      fail_count   <= fail_d;
      key_error    <= error_d;
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
`timescale 1ns/1ps
// Bench for lock_sequencer: directed steps plus random strobes, checked every cycle against
// a reference model built from remaining-time counts and a list of accepted keys.
module tb_lock_sequencer;

  localparam int unsigned MAXP  = 10;
  localparam int unsigned MAXF  = 3;
  localparam int unsigned OPENC = 1000;
  localparam int unsigned LOCKC = 5000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       lock_open = 1'b0;
  logic       lock_reset, lock_try, unlocked, locked_out, key_error;
  logic [3:0] lock_numbers;
  logic [1:0] fail_count;

  int compared = 0;
  int mismatched = 0;
  int n_unl, n_lko, n_try;

  // Reference model
  bit         m_clr, m_check;
  int         open_left, lock_left, fails;
  int         q[$];
  logic [3:0] e_num;
  bit         e_try, e_err;

  lock_sequencer #(.MAX_PRESSES(MAXP), .MAX_FAILS(MAXF), .OPEN_CYCLES(OPENC),
                   .LOCKOUT_CYCLES(LOCKC)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key(key), .enter(enter),
    .clear(clear), .lock_open(lock_open), .lock_reset(lock_reset),
    .lock_numbers(lock_numbers), .lock_try(lock_try), .unlocked(unlocked),
    .locked_out(locked_out), .fail_count(fail_count), .key_error(key_error));

  always #5 clk = ~clk;

  // The lock opens when the presses since its reset are one 0001, two 0010, three 0100, four 1000.
  function automatic bit code_ok();
    int c0 = 0, c1 = 0, c2 = 0, c3 = 0;
    foreach (q[i]) begin
      if (q[i] == 1) c0++;
      if (q[i] == 2) c1++;
      if (q[i] == 4) c2++;
      if (q[i] == 8) c3++;
    end
    return (c0 == 1) && (c1 == 2) && (c2 == 3) && (c3 == 4) && (q.size() == 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("lock_reset",   32'(lock_reset),   32'(m_clr));
    check("lock_numbers", 32'(lock_numbers), 32'(e_num));
    check("lock_try",     32'(lock_try),     32'(e_try));
    check("unlocked",     32'(unlocked),     32'(open_left > 0));
    check("locked_out",   32'(locked_out),   32'(lock_left > 0));
    check("fail_count",   32'(fail_count),   32'(fails));
    check("key_error",    32'(key_error),    32'(e_err));
  endtask

  task automatic model_reset();
    m_clr = 1'b1; m_check = 1'b0; open_left = 0; lock_left = 0; fails = 0;
    q.delete(); e_num = 4'd0; e_try = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] k, input bit en, input bit cl);
    e_try = 1'b0;
    e_err = 1'b0;
    if (m_clr) begin
      m_clr = 1'b0;
      q.delete();
    end else if (m_check) begin
      m_check = 1'b0;
      if (code_ok()) begin
        open_left = OPENC;
        fails = 0;
      end else begin
        if (fails < MAXF) fails++;
        if (fails == MAXF) lock_left = LOCKC;
        else               m_clr = 1'b1;
      end
    end else if (open_left > 0) begin
      if (cl || open_left == 1) begin open_left = 0; m_clr = 1'b1; end
      else open_left--;
    end else if (lock_left > 0) begin
      if (lock_left == 1) begin lock_left = 0; fails = 0; m_clr = 1'b1; end
      else lock_left--;
    end else if (cl) begin
      m_clr = 1'b1;
    end else if (en) begin
      if (q.size() > 0) m_check = 1'b1;
    end else if (kv) begin
      if ($countones(k) == 1 && q.size() < MAXP) begin
        q.push_back(int'(k));
        e_num = k;
        e_try = 1'b1;
      end else begin
        e_err = 1'b1;
      end
    end
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, check at the next falling edge.
  task automatic cycle(input bit kv, input logic [3:0] k, input bit en, input bit cl);
    key_valid = kv; key = k; enter = en; clear = cl;
    lock_open = code_ok();
    @(posedge clk);
    model_step(kv, k, en, cl);
    @(negedge clk);
    n_unl += int'(unlocked);
    n_lko += int'(locked_out);
    n_try += int'(lock_try);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, k, 1'b0, 1'b0);
  endtask

  task automatic rand_cycle(input bit allow_clear);
    logic [3:0] k;
    if ($urandom_range(0, 3) != 0) k = 4'(1 << $urandom_range(0, 3));
    else                           k = 4'($urandom_range(0, 15));
    cycle(1'($urandom_range(0, 1)), k, ($urandom_range(0, 9) == 0),
          allow_clear && ($urandom_range(0, 15) == 0));
  endtask

  task automatic correct_code();
    press(4'b0001, 1); press(4'b0010, 2); press(4'b0100, 3); press(4'b1000, 4);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset held, then released
    model_reset();
    for (int i = 0; i < 3; i++) begin @(negedge clk); check_all(); end
    reset_n = 1'b1;
    check_all();
    idle(2);

    // Correct code: ten tries, unlocked for the full window with random ignored keys/enters
    n_try = 0; n_unl = 0;
    correct_code();
    check("try_pulses", 32'(n_try), 32'd10);
    for (int i = 0; i < OPENC + 4; i++) rand_cycle(1'b0);
    check("unlocked_cycles", 32'(n_unl), 32'(OPENC));

    // Three failed attempts, lockout with random strobes including clear
    n_lko = 0;
    for (int a = 0; a < 3; a++) begin
      press(4'b0001, 2);
      cycle(1'b0, 4'd0, 1'b1, 1'b0);
      idle(3);
    end
    for (int i = 0; i < LOCKC; i++) rand_cycle(1'b1);
    check("lockout_cycles", 32'(n_lko), 32'(LOCKC));
    check("fail_after_lockout", 32'(fail_count), 32'd0);

    // Key errors: two bits, eleventh key, zero key
    press(4'b0011, 1);
    press(4'b0001, 10);
    press(4'b0100, 1);
    press(4'b0000, 1);
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    idle(2);

    // Simultaneous strobes in ENTRY
    press(4'b0010, 1);
    cycle(1'b1, 4'b0001, 1'b1, 1'b1);
    idle(2);
    press(4'b0010, 1);
    cycle(1'b1, 4'b0001, 1'b1, 1'b0);
    idle(3);

    // Reset 500 cycles into OPEN, then unlock again
    correct_code();
    idle(500);
    #1 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;
    check_all();
    idle(1);
    n_unl = 0;
    correct_code();
    idle(OPENC + 3);
    check("unlocked_cycles_2", 32'(n_unl), 32'(OPENC));

    // Random traffic
    for (int i = 0; i < 600; i++) rand_cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Synchronous front-end controller for the `lock` combination datapath. It accepts keypad strobes and drives the lock's `reset`, `numbers` and `try` inputs, one press per `try` pulse. It samples `open` on an enter request, holds the unlocked condition for a fixed time and enforces a timed lockout after repeated failed attempts. It sits between the debounced keypad logic and the `lock` instance.

## Interface
- `MAX_PRESSES`, default 10: maximum accepted key presses per attempt; 10 covers the full 1+2+3+4 code.
- `MAX_FAILS`, default 3: consecutive failed attempts that trigger lockout.
- `OPEN_CYCLES`, default 1000: cycles `unlocked` stays high.
- `LOCKOUT_CYCLES`, default 5000: cycles `locked_out` stays high.

Ports:
- `clk` in 1: single clock. All logic is posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle key press strobe.
- `key` in 4: button code, qualified by `key_valid`. Must be one-hot.
- `enter` in 1: one-cycle strobe that submits the attempt.
- `clear` in 1: one-cycle strobe that abandons the attempt.
- `lock_open` in 1: `open` output of the lock.
- `lock_reset` out 1: drives the lock's `reset`. Active-high.
- `lock_numbers` out 4: drives the lock's `numbers`.
- `lock_try` out 1: drives the lock's `try`. One-cycle pulse.
- `unlocked` out 1: high in OPEN.
- `locked_out` out 1: high in LOCKOUT.
- `fail_count` out $clog2(MAX_FAILS+1): consecutive failed attempts.
- `key_error` out 1: one-cycle pulse on a rejected key.

## Operation
- All outputs are registered.
- Reset values: `lock_reset`=1, `lock_numbers`=0, `lock_try`=0, `unlocked`=0, `locked_out`=0, `fail_count`=0, `key_error`=0. State = CLR, press count = 0.
- Input priority in a single cycle is `clear` > `enter` > `key_valid`. Lower-priority strobes in the same cycle are dropped silently.
- A key is accepted only when `key` is one-hot and press count < MAX_PRESSES. Acceptance loads `lock_numbers`=`key`, pulses `lock_try` and increments the press count.
- A `key_valid` with a non-one-hot `key` (0, or two or more bits set) pulses `key_error`, with no `try` and no count change.
- A `key_valid` with a one-hot `key` while press count = MAX_PRESSES also pulses `key_error`, with no `try` and no count change.

State machine:
- CLR: `lock_reset`=1, press count cleared. Next state is IDLE unconditionally.
- IDLE: accepted key → ENTRY. `clear` → CLR. `enter` is ignored.
- ENTRY: accepted key stays in ENTRY. `enter` → CHECK. `clear` → CLR.
- CHECK: one cycle. Samples `lock_open`.
  - `lock_open`=1 → OPEN. Load timer with OPEN_CYCLES-1 and clear `fail_count`.
  - `lock_open`=0 → increment `fail_count`. If the new value = MAX_FAILS → LOCKOUT, loading the timer with LOCKOUT_CYCLES-1. Otherwise → CLR.
- OPEN: `unlocked`=1. Keys and `enter` are ignored. The timer decrements each cycle. `clear` or timer = 0 → CLR.
- LOCKOUT: `locked_out`=1. All strobes, including `clear`, are ignored. At timer = 0 → CLR and clear `fail_count`.

Widths and arithmetic:
- `fail_count` saturates at MAX_FAILS and never wraps.
- The timer width is $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)).
- The press counter width is $clog2(MAX_PRESSES+1).
- MAX_PRESSES ≤ 15 is required so that no lock digit counter wraps.

Other rules:
- `key_error` is never raised outside IDLE and ENTRY.
- Asserting `reset_n` low in any state forces all reset values immediately, including mid-OPEN and mid-LOCKOUT.

## Timing
- Latency: an accepted key in cycle N gives `lock_numbers` valid and `lock_try`=1 in cycle N+1, with `lock_try` back to 0 in N+2.
- `lock_numbers` holds its value until the next accepted key; it is stable around the `try` edge.
- `enter` in cycle N gives CHECK in N+1; `lock_open` is sampled at the end of N+1. An `enter` in the cycle immediately after a `try` pulse is legal, because `open` settles within the `try` cycle.
- `unlocked` is high for exactly OPEN_CYCLES cycles when not cleared.
- `locked_out` is high for exactly LOCKOUT_CYCLES cycles.
- Each visit to CLR gives `lock_reset` high for exactly one cycle.
- After `reset_n` deasserts, `lock_reset` stays high for one CLR cycle and then drops.
- `lock_try` and `lock_reset` are never high in the same cycle.

## Test plan
- Reset check: hold `reset_n`=0 → `lock_reset`=1 and all other outputs 0. Release → `lock_reset`=1 for one more cycle, then 0 with the FSM in IDLE.
- Correct code: keys 0001×1, 0010×2, 0100×3, 1000×4, then `enter` → ten `lock_try` pulses, each with matching `lock_numbers`; `unlocked` high for 1000 cycles; then one `lock_reset` pulse; `fail_count`=0.
- Failed attempts: three wrong attempts (0001×2 + `enter`) → `fail_count` reads 1, 2, then `locked_out` high for 5000 cycles. A `clear` during lockout has no effect. At exit `fail_count`=0 and `lock_reset` pulses.
- Key errors: `key`=0011 → `key_error` pulse with no `try`. An 11th valid key → `key_error` pulse with press count held at 10. `key`=0000 → `key_error` pulse.
- Simultaneous strobes in ENTRY: `clear`+`enter`+`key_valid` → CLR with no `try`. `enter`+`key_valid` → CHECK with no `try`.
- Reset mid-operation: drive `reset_n` low 500 cycles into OPEN → `unlocked`=0 and `lock_reset`=1 immediately. After release, a correct code unlocks again.
